// File: rtl/seed_round_sync.sv
`default_nettype none
// ============================================================================
//  Module   : seed_round_sync
//  Purpose  : Start/sync/load/done sequencer for one multi-round SEED block.
//  Revision : 1.0  - initial release
// ============================================================================
module seed_round_sync #(
  parameter int NUM_ROUNDS   = 16,
  parameter int ROUND_CYCLES = 4,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             go,
  input  logic             dec,
  output logic             busy,
  output logic             start,
  output logic             sync,
  output logic             load,
  output logic [IDX_W-1:0] round_idx,
  output logic             done
);

  localparam int                 c_cyc_w    = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(ROUND_CYCLES - 1);
  localparam logic [IDX_W-1:0]   c_rnd_last = IDX_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [c_cyc_w-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [IDX_W-1:0]   rnd_cnt_q, rnd_cnt_d;
  logic               dec_q, dec_d;
  logic               round_sync;

  // Last clock-enabled cycle of a round: the strobe that closes it.
  assign round_sync = (state_q == S_RUN) && (cyc_cnt_q == c_cyc_last);

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    dec_d     = dec_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d   = S_LOAD;
            dec_d     = dec;
            cyc_cnt_d = '0;
            rnd_cnt_d = '0;
          end
        end
        S_LOAD: begin
          state_d   = S_RUN;
          cyc_cnt_d = '0;
          rnd_cnt_d = '0;
        end
        S_RUN: begin
          if (round_sync) begin
            cyc_cnt_d = '0;
            // The final round's index is kept through DONE.
            if (rnd_cnt_q == c_rnd_last) begin
              state_d = S_DONE;
            end else begin
              rnd_cnt_d = rnd_cnt_q + IDX_W'(1);
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + c_cyc_w'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    start     = (state_q == S_LOAD) || (state_q == S_RUN);
    sync      = (state_q == S_LOAD) || round_sync;
    load      = (state_q == S_LOAD);
    done      = (state_q == S_DONE);
    round_idx = dec_q ? (c_rnd_last - rnd_cnt_q) : rnd_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      rnd_cnt_q <= '0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      rnd_cnt_q <= rnd_cnt_d;
      dec_q     <= dec_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seed_round_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seed_round_sync
//  Purpose  : Scoreboard bench for seed_round_sync (default and 2x1 configs).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_seed_round_sync;

  typedef struct packed {
    int   t;
    logic sy;
    logic st;
    logic ld;
    logic dn;
    logic bz;
    int   idx;
  } evt_t;

  logic clk = 1'b0;
  logic reset, clk_en, go, dec, go1, dec1;
  logic busy0, start0, sync0, load0, done0;
  logic [3:0] idx0;
  logic busy1, start1, sync1, load1, done1;
  logic [0:0] idx1;
  logic [8:0] o0_now, o0_prev;
  logic [5:0] o1_now;
  logic prev_valid = 1'b0;
  logic prev_en    = 1'b0;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;
  int t0;
  evt_t q0[$];
  evt_t q1[$];

  seed_round_sync #(.NUM_ROUNDS(16), .ROUND_CYCLES(4), .IDX_W(4)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .go(go), .dec(dec),
    .busy(busy0), .start(start0), .sync(sync0), .load(load0),
    .round_idx(idx0), .done(done0)
  );

  seed_round_sync #(.NUM_ROUNDS(2), .ROUND_CYCLES(1), .IDX_W(1)) u_dut_small (
    .clk(clk), .reset(reset), .clk_en(1'b1), .go(go1), .dec(dec1),
    .busy(busy1), .start(start1), .sync(sync1), .load(load1),
    .round_idx(idx1), .done(done1)
  );

  assign o0_now = {busy0, start0, sync0, load0, done0, idx0};
  assign o1_now = {busy1, start1, sync1, load1, done1, idx1};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cycle);
    end
  endtask

  task automatic cmp_evt(input string nm, input evt_t g, input evt_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got t=%0d sync=%0b start=%0b load=%0b done=%0b busy=%0b idx=%0d expected t=%0d sync=%0b start=%0b load=%0b done=%0b busy=%0b idx=%0d",
               nm, g.t, g.sy, g.st, g.ld, g.dn, g.bz, g.idx, e.t, e.sy, e.st, e.ld, e.dn, e.bz, e.idx);
    end
  endtask

  function automatic void put(input bit sel, input evt_t e);
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endfunction

  // Expected strobes of one block whose go is sampled at the end of cycle t;
  // s is the clk-cycle stretch applied by a toggling enable.
  function automatic void push_block(input bit sel, input int t, input bit d,
                                     input int nr, input int rc, input int s);
    evt_t e;
    e = '{t: t + s, sy: 1'b1, st: 1'b1, ld: 1'b1, dn: 1'b0, bz: 1'b1, idx: d ? nr - 1 : 0};
    put(sel, e);
    for (int r = 0; r < nr; r++) begin
      e = '{t: t + s * (1 + (r + 1) * rc), sy: 1'b1, st: 1'b1, ld: 1'b0, dn: 1'b0, bz: 1'b1,
            idx: d ? nr - 1 - r : r};
      put(sel, e);
    end
    e = '{t: t + s * (2 + nr * rc), sy: 1'b0, st: 1'b0, ld: 1'b0, dn: 1'b1, bz: 1'b1,
          idx: d ? 0 : nr - 1};
    put(sel, e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the default instance: strobes and hold-while-disabled.
  always @(negedge clk) begin
    evt_t g;
    if (!reset) begin
      if (prev_valid && !prev_en) chk("hold_when_disabled", int'(o0_now), int'(o0_prev));
      if (clk_en && (sync0 || done0)) begin
        g = '{t: cycle, sy: sync0, st: start0, ld: load0, dn: done0, bz: busy0, idx: int'(idx0)};
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe0: got t=%0d sync=%0b done=%0b expected none", cycle, sync0, done0);
        end else begin
          cmp_evt("strobe0", g, q0.pop_front());
        end
      end
    end
    prev_valid = !reset;
    prev_en    = clk_en;
    o0_prev    = o0_now;
  end

  always @(negedge clk) begin
    evt_t g;
    if (!reset && (sync1 || done1)) begin
      g = '{t: cycle, sy: sync1, st: start1, ld: load1, dn: done1, bz: busy1, idx: int'(idx1)};
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe1: got t=%0d sync=%0b done=%0b expected none", cycle, sync1, done1);
      end else begin
        cmp_evt("strobe1", g, q1.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; clk_en = 1'b0; go = 1'b0; dec = 1'b0; go1 = 1'b0; dec1 = 1'b0;
    repeat (3) tick();
    chk("reset_outputs0", int'(o0_now), 0);
    chk("reset_outputs1", int'(o1_now), 0);
    reset = 1'b0; clk_en = 1'b1;
    tick();

    // Encrypt, nominal timing.
    t0 = cycle; go = 1'b1; dec = 1'b0;
    push_block(1'b0, t0, 1'b0, 16, 4, 1);
    tick(); go = 1'b0;
    repeat (70) tick();
    chk("idle_after_encrypt", int'(busy0), 0);

    // Decrypt; dec is dropped right after it has been latched.
    t0 = cycle; go = 1'b1; dec = 1'b1;
    push_block(1'b0, t0, 1'b1, 16, 4, 1);
    tick(); go = 1'b0; dec = 1'b0;
    repeat (70) tick();
    chk("idle_after_decrypt", int'(busy0), 0);

    // Enable toggling every cycle stretches the whole block by two.
    t0 = cycle; go = 1'b1;
    push_block(1'b0, t0, 1'b0, 16, 4, 2);
    tick(); go = 1'b0; clk_en = 1'b0;
    for (int i = 0; i < 140; i++) begin
      tick();
      clk_en = ~clk_en;
    end
    clk_en = 1'b1;
    repeat (2) tick();
    chk("idle_after_stretch", int'(busy0), 0);

    // Reset in the middle of RUN, then a fresh nominal block.
    t0 = cycle; go = 1'b1;
    push_block(1'b0, t0, 1'b0, 16, 4, 1);
    tick(); go = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q0.delete();
    chk("midrun_reset_outputs", int'(o0_now), 0);
    repeat (2) tick();
    t0 = cycle; go = 1'b1;
    push_block(1'b0, t0, 1'b0, 16, 4, 1);
    tick(); go = 1'b0;
    repeat (70) tick();
    chk("idle_after_restart", int'(busy0), 0);

    // go held high: back-to-back blocks, dec wiggled during the first one.
    t0 = cycle; go = 1'b1; dec = 1'b0;
    push_block(1'b0, t0, 1'b0, 16, 4, 1);
    push_block(1'b0, t0 + 67, 1'b0, 16, 4, 1);
    while (cycle < t0 + 140) begin
      tick();
      if (cycle == t0 + 20) dec = 1'b1;
      if (cycle == t0 + 40) dec = 1'b0;
      if (cycle == t0 + 68) go = 1'b0;
    end
    chk("idle_after_back_to_back", int'(busy0), 0);

    // Two rounds of one cycle each, encrypt then decrypt.
    t0 = cycle; go1 = 1'b1; dec1 = 1'b0;
    push_block(1'b1, t0, 1'b0, 2, 1, 1);
    tick(); go1 = 1'b0;
    repeat (4) tick();
    chk("small_idle_at_t5", int'(busy1), 0);
    t0 = cycle; go1 = 1'b1; dec1 = 1'b1;
    push_block(1'b1, t0, 1'b1, 2, 1, 1);
    tick(); go1 = 1'b0; dec1 = 1'b0;
    repeat (4) tick();
    chk("small_idle_after_decrypt", int'(busy1), 0);

    repeat (3) tick();
    chk("scoreboard0_drained", q0.size(), 0);
    chk("scoreboard1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
